// File: rtl/mem_write_arbiter_pkg.sv
// Shared definitions for the multi-channel write arbiter: FSM state
// encodings and the grant-index width helper.
package mem_write_arbiter_pkg;

    // Gray-ordered encodings: IDLE -> WRITE -> WAIT flips one bit per step.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_WAIT  = 2'b11
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int gw_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// strictly after the last-granted one, searching upward with wrap.
module rr_arbiter
    import mem_write_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]               i_req,
    input  logic [gw_width(NUM_CH)-1:0]     i_last,
    output logic [NUM_CH-1:0]               o_grant,
    output logic [gw_width(NUM_CH)-1:0]     o_idx,
    output logic                            o_any
);

    localparam int GW = gw_width(NUM_CH);

    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_sel;

    // Requests above the pointer take precedence; if none, wrap to the
    // full request vector. The lowest set bit of the chosen vector wins.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_mask[i] = i_req[i] & (i > 32'(i_last));
        end
        w_sel   = (|w_mask) ? w_mask : i_req;
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (w_sel[i-1]) begin
                o_grant      = '0;
                o_grant[i-1] = 1'b1;
                o_idx        = GW'(i - 1);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mem_write_arbiter.sv
// Multi-channel write arbiter: round-robin selection among valid/ready
// producers, one registered write strobe per grant, then a programmable
// recovery gap before the next grant.
module mem_write_arbiter
    import mem_write_arbiter_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               ch_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]    ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    ch_data,
    output logic [NUM_CH-1:0]               ch_ready,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            idle,
    output logic [gw_width(NUM_CH)-1:0]     grant_id,
    output logic [CNT_WIDTH-1:0]            write_count
);

    localparam int GW = gw_width(NUM_CH);
    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WW'(WAIT_CYCLES - 1) : '0;

    state_t                 r_state;
    logic                   r_we;
    logic [NUM_CH-1:0]      r_ready;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [GW-1:0]          r_gid;
    logic [WW-1:0]          r_wcnt;
    logic [CNT_WIDTH-1:0]   r_count;

    state_t                 w_state_nxt;
    logic                   w_we_nxt;
    logic [NUM_CH-1:0]      w_ready_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic [GW-1:0]          w_gid_nxt;
    logic [WW-1:0]          w_wcnt_nxt;
    logic [CNT_WIDTH-1:0]   w_count_nxt;

    logic [NUM_CH-1:0]      w_grant;
    logic [GW-1:0]          w_idx;
    logic                   w_any;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (ch_valid),
        .i_last  (r_gid),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Pick the granted channel's address and data out of the flattened buses.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; strobes default low so any
    // unlisted state falls back to IDLE with nothing asserted.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_we_nxt    = 1'b0;
        w_ready_nxt = '0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_gid_nxt   = r_gid;
        w_wcnt_nxt  = r_wcnt;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_WRITE;
                    w_we_nxt    = 1'b1;
                    w_ready_nxt = w_grant;
                    w_addr_nxt  = w_sel_addr;
                    w_data_nxt  = w_sel_data;
                    w_gid_nxt   = w_idx;
                end
            end
            ST_WRITE: begin
                w_count_nxt = r_count + 1'b1;
                if (WAIT_CYCLES > 0) begin
                    w_state_nxt = ST_WAIT;
                    w_wcnt_nxt  = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_wcnt_nxt  = r_wcnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; the
    // pointer resets to the top channel so channel 0 is served first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_ready <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_gid   <= GW'(NUM_CH - 1);
            r_wcnt  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_ready <= w_ready_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_gid   <= w_gid_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign ch_ready    = r_ready;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_data;
    assign idle        = (r_state == ST_IDLE);
    assign grant_id    = r_gid;
    assign write_count = r_count;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: instance A uses WAIT_CYCLES=1 with a
// 4-bit counter (to reach the wrap), instance B uses WAIT_CYCLES=0.
module tb_mem_write_arbiter;
    import mem_write_arbiter_pkg::*;

    localparam int NCH = 4;
    localparam int AW  = 5;
    localparam int DW  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NCH-1:0]    a_valid, b_valid;
    logic [NCH*AW-1:0] a_addr,  b_addr;
    logic [NCH*DW-1:0] a_data,  b_data;

    logic [NCH-1:0] a_ready, b_ready;
    logic           a_we,    b_we;
    logic [AW-1:0]  a_maddr, b_maddr;
    logic [DW-1:0]  a_wdata, b_wdata;
    logic           a_idle,  b_idle;
    logic [1:0]     a_gid,   b_gid;
    logic [3:0]     a_cnt;
    logic [15:0]    b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mem_write_arbiter #(
        .NUM_CH      (NCH),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (1),
        .CNT_WIDTH   (4)
    ) u_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_valid    (a_valid),
        .ch_addr     (a_addr),
        .ch_data     (a_data),
        .ch_ready    (a_ready),
        .mem_we      (a_we),
        .mem_addr    (a_maddr),
        .mem_wdata   (a_wdata),
        .idle        (a_idle),
        .grant_id    (a_gid),
        .write_count (a_cnt)
    );

    mem_write_arbiter #(
        .NUM_CH      (NCH),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (0),
        .CNT_WIDTH   (16)
    ) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_valid    (b_valid),
        .ch_addr     (b_addr),
        .ch_data     (b_data),
        .ch_ready    (b_ready),
        .mem_we      (b_we),
        .mem_addr    (b_maddr),
        .mem_wdata   (b_wdata),
        .idle        (b_idle),
        .grant_id    (b_gid),
        .write_count (b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_addr[ch*AW +: AW] = ad;
        a_data[ch*DW +: DW] = d;
    endtask

    task automatic set_b(input int ch, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_addr[ch*AW +: AW] = ad;
        b_data[ch*DW +: DW] = d;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_we"},    64'(a_we),    64'd0);
        chk({tag, "_ready"}, 64'(a_ready), 64'd0);
        chk({tag, "_addr"},  64'(a_maddr), 64'd0);
        chk({tag, "_data"},  64'(a_wdata), 64'd0);
        chk({tag, "_gid"},   64'(a_gid),   64'd3);
        chk({tag, "_cnt"},   64'(a_cnt),   64'd0);
        chk({tag, "_idle"},  64'(a_idle),  64'd1);
    endtask

    // Advance until instance A strobes mem_we or the budget runs out.
    task automatic wait_a_we(input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!a_we && waited < budget);
        chk("we_timeout", 64'(a_we), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int nwe;
        int seen;
        int exp_ord[5];
        logic [DW-1:0] words[3];
        exp_ord  = '{0, 1, 2, 3, 0};
        words    = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

        a_valid = '0; a_addr = '0; a_data = '0;
        b_valid = '0; b_addr = '0; b_data = '0;

        // reset values
        rst_n = 1'b0;
        repeat (3) tick();
        chk_a_reset("rst");
        chk("rst_b_idle", 64'(b_idle), 64'd1);
        chk("rst_b_gid",  64'(b_gid),  64'd3);
        rst_n = 1'b1;
        tick();

        // single request on ch1
        set_a(1, 5'd5, 32'hDEAD_BEEF);
        a_valid = 4'b0010;
        tick();
        chk("single_we",    64'(a_we),    64'd1);
        chk("single_addr",  64'(a_maddr), 64'd5);
        chk("single_data",  64'(a_wdata), 64'hDEAD_BEEF);
        chk("single_ready", 64'(a_ready), 64'b0010);
        chk("single_gid",   64'(a_gid),   64'd1);
        chk("single_idle",  64'(a_idle),  64'd0);
        tick();
        chk("single_wait_we",    64'(a_we),    64'd0);
        chk("single_wait_ready", 64'(a_ready), 64'd0);
        chk("single_wait_idle",  64'(a_idle),  64'd0);
        a_valid = '0;
        tick();
        chk("single_idle_again", 64'(a_idle),  64'd1);
        chk("single_cnt",        64'(a_cnt),   64'd1);
        chk("single_addr_hold",  64'(a_maddr), 64'd5);

        // round-robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) set_a(i, AW'(8 + i), 32'hA0 + DW'(i));
        a_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_a_we(6, w);
            if (k == 0) chk("rr_latency", 64'(w), 64'd1);
            else        chk("rr_gap",     64'(w), 64'd3);
            chk("rr_gid",   64'(a_gid),   64'(exp_ord[k]));
            chk("rr_ready", 64'(a_ready), 64'd1 << exp_ord[k]);
            chk("rr_addr",  64'(a_maddr), 64'(8 + exp_ord[k]));
            chk("rr_data",  64'(a_wdata), 64'(32'hA0 + exp_ord[k]));
        end
        tick();
        a_valid = '0;
        tick();
        chk("rr_cnt",  64'(a_cnt),  64'd5);
        chk("rr_idle", 64'(a_idle), 64'd1);

        // ch3 raises valid while busy and drops it before it can be granted
        a_valid = 4'b0001;
        tick();
        chk("drop_ch0_gid", 64'(a_gid), 64'd0);
        a_valid = 4'b1001;
        tick();
        a_valid = 4'b0000;
        tick();
        nwe = 0;
        repeat (4) begin
            tick();
            if (a_we) nwe++;
        end
        chk("drop_no_we", 64'(nwe),   64'd0);
        chk("drop_cnt",   64'(a_cnt), 64'd6);
        chk("drop_gid",   64'(a_gid), 64'd0);

        // reset pulsed during WAIT
        a_valid = 4'b0010;
        tick();
        tick();
        a_valid = '0;
        chk("rstw_in_wait", 64'(a_idle), 64'd0);
        rst_n = 1'b0;
        tick();
        chk_a_reset("rstw");
        rst_n = 1'b1;

        // 17 writes into a 4-bit counter
        set_a(0, 5'd3, 32'h1234_5678);
        a_valid = 4'b0001;
        seen = 0;
        for (int t = 0; t < 80 && seen < 17; t++) begin
            tick();
            if (a_we) seen++;
        end
        chk("wrap_seen", 64'(seen), 64'd17);
        tick();
        a_valid = '0;
        tick();
        chk("wrap_cnt",  64'(a_cnt),  64'd1);
        chk("wrap_idle", 64'(a_idle), 64'd1);

        // illegal state encoding recovers to IDLE without a strobe
        set_a(2, 5'd17, 32'hCAFE_0002);
        force u_a.r_state = state_t'(2'b10);
        a_valid = 4'b0100;
        @(negedge clk);
        chk("ill_not_idle", 64'(a_idle), 64'd0);
        release u_a.r_state;
        tick();
        chk("ill_idle",  64'(a_idle),  64'd1);
        chk("ill_we",    64'(a_we),    64'd0);
        chk("ill_ready", 64'(a_ready), 64'd0);
        tick();
        chk("ill_grant_we",  64'(a_we),  64'd1);
        chk("ill_grant_gid", 64'(a_gid), 64'd2);
        tick();
        a_valid = '0;
        tick();

        // WAIT_CYCLES=0: ch2 streams three words, one write every 2nd cycle
        set_b(2, 5'd9, words[0]);
        b_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("w0_we",    64'(b_we),    64'd1);
            chk("w0_data",  64'(b_wdata), 64'(words[k]));
            chk("w0_ready", 64'(b_ready), 64'b0100);
            chk("w0_addr",  64'(b_maddr), 64'd9);
            tick();
            chk("w0_gap_we",   64'(b_we),   64'd0);
            chk("w0_gap_idle", 64'(b_idle), 64'd1);
            if (k < 2) set_b(2, 5'd9, words[k+1]);
            else       b_valid = '0;
        end
        tick();
        chk("w0_cnt", 64'(b_cnt), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_write_arbiter.md
# mem_write_arbiter

Multi-channel successor to the single-port write capture FSM. It accepts write requests from NUM_CH independent producers over a valid/ready handshake and arbitrates among them round-robin. Each granted request goes out as a single-cycle registered write strobe on one shared memory write port, followed by a programmable recovery gap. It sits between several write-issuing engines and one register-file or BRAM write port.

## Interface
- NUM_CH, 4: number of request channels; legal range 2 to 16.
- DATA_WIDTH, 32: write data width.
- ADDR_WIDTH, 5: write address width.
- WAIT_CYCLES, 1: recovery cycles after each write; 0 is legal.
- CNT_WIDTH, 16: width of the completed-write counter.
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ch_valid  in  NUM_CH  per-channel request valid.
- ch_addr  in  NUM_CH*ADDR_WIDTH  flattened addresses; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_data  in  NUM_CH*DATA_WIDTH  flattened data, packed the same way.
- ch_ready  out  NUM_CH  one-hot, registered; accept pulse for the granted channel.
- mem_we  out  1  registered write strobe.
- mem_addr  out  ADDR_WIDTH  registered write address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- idle  out  1  high while the FSM is in IDLE.
- grant_id  out  GW  index of the last granted channel; GW = $clog2(NUM_CH).
- write_count  out  CNT_WIDTH  completed writes; wraps modulo 2^CNT_WIDTH.

## Operation
- **States:** IDLE, WRITE, WAIT.
- **IDLE:**
  - With no valid requests, the FSM stays in IDLE.
  - With any ch_valid high, the round-robin arbiter picks the first valid channel after the last grant, searching upward with wrap.
  - At that edge: latch the granted channel's addr and data into mem_addr/mem_wdata, load grant_id, go to WRITE.
- **WRITE (exactly 1 cycle):**
  - mem_we=1 and ch_ready[grant_id]=1.
  - write_count increments at the end of the cycle.
  - Next state is WAIT if WAIT_CYCLES>0, else IDLE.
- **WAIT:**
  - A down-counter is loaded with WAIT_CYCLES-1 on entry.
  - Return to IDLE when the counter reaches 0.
  - mem_we=0 and ch_ready=0 throughout.
- **Handshake rules:**
  - A producer holds valid, addr and data stable until it samples ch_ready high.
  - The transfer completes at the edge where ch_ready is high.
  - The producer may present a new request, or drop valid, on the following cycle.
  - Values are captured on the IDLE→WRITE edge. Changes made after that edge do not affect the in-flight write.
- **Fairness:** the last-grant pointer updates only on grant. A channel that holds valid continuously is served within NUM_CH grants.
- **Simultaneous requests:** when several channels are valid in the same cycle, exactly one is granted; the others wait.
- **Dropped request:** a channel that drops valid before being granted is skipped silently, with no error.
- **Illegal state:** any illegal state encoding returns to IDLE on the next edge with all strobes low.
- **Reset:**
  - Values: state=IDLE, mem_we=0, ch_ready=0, mem_addr=0, mem_wdata=0, grant_id=NUM_CH-1 (so channel 0 has first priority), write_count=0, idle=1.
- **Reset mid-operation:** at the reset edge, an in-flight WRITE or WAIT is abandoned. If reset is sampled during the WRITE cycle, that write still counts as issued, but write_count is cleared.

## Timing
- **Latency:** a request that is valid in cycle N while IDLE gives mem_we and ch_ready high in cycle N+1.
- **Back-to-back:** the FSM is in IDLE again at N+2+WAIT_CYCLES and can grant at that edge.
- **Throughput:** one write per 2+WAIT_CYCLES cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- mem_addr and mem_wdata hold their last value outside WRITE.

## Structure
- **Shared package:**
  - state encodings: IDLE=2'b00, WRITE=2'b01, WAIT=2'b11, all in Gray order;
  - the GW width function.
- **Sub-module rr_arbiter:**
  - parameter NUM_CH;
  - inputs: req vector, last-grant pointer;
  - outputs: one-hot grant, encoded index, any_req;
  - purely combinational.
- The FSM, the wait counter, the output registers and write_count stay in mem_write_arbiter.

## Test plan
- **Reset values:** hold rst_n=0 for 3 cycles → all outputs at reset values, idle=1, write_count=0.
- **Single request, WAIT_CYCLES=1:** ch1 valid with addr=5, data=0xDEADBEEF in cycle N → mem_we=1, mem_addr=5, mem_wdata=0xDEADBEEF, ch_ready=4'b0010 in cycle N+1; idle=1 again at N+3; write_count=1.
- **Round-robin:** all 4 channels valid continuously → grant order 0,1,2,3,0; one mem_we every 3 cycles; no channel is granted twice within 4 grants.
- **WAIT_CYCLES=0:** ch2 held valid with 3 successive data words → mem_we is high every 2nd cycle, and the data appear in order.
- **Mid-flight drop and reset:**
  - ch3 drops valid before grant → no write is issued for ch3.
  - rst_n pulsed low during WAIT → outputs at reset values on the next cycle, write_count=0.
- **Wrap and illegal state:**
  - CNT_WIDTH=4 with 17 writes → write_count=1.
  - Force the state to 2'b10 → IDLE on the next edge, mem_we=0.
